// File: rtl/vpu_scoreboard_pkg.sv
// Shared types for the VPU VRF shadow checker: shadow geometry, SEW encoding,
// compare FSM states and the result record. Optional feature: VPU_SB_WRITTEN_TRACK_EN.
package vpu_scoreboard_pkg;

  localparam int SB_N_LANES    = 8;
  localparam int SB_DATA_W     = 64;
  localparam int SB_N_VREGS    = 32;
  localparam int SB_LANE_DEPTH = 32;
  localparam int SB_CNT_W      = 16;
  localparam int SB_VREG_W     = 5;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2,
    SEW_64 = 2'd3
  } sew_e;

  typedef enum logic [1:0] {
    CHK_IDLE = 2'd0,
    CHK_CMP  = 2'd1,
    CHK_DONE = 2'd2
  } chk_state_e;

  typedef struct packed {
    logic                error;
    logic [SB_CNT_W-1:0] elem_idx;
    logic [SB_CNT_W-1:0] mm_cnt;
    logic                hazard;
  } chk_result_t;

  function automatic logic [SB_CNT_W-1:0] sat_inc(input logic [SB_CNT_W-1:0] v);
    return (&v) ? v : v + SB_CNT_W'(1);
  endfunction

endpackage

// File: rtl/vpu_sb_lane_shadow.sv
// Per-lane shadow of the VRF: byte-enabled write port, combinational read port.
// With VPU_SB_WRITTEN_TRACK_EN a per-byte written bit is kept alongside the data.
module vpu_sb_lane_shadow
  import vpu_scoreboard_pkg::*;
#(
  parameter int DATA_W     = SB_DATA_W,
  parameter int N_VREGS    = SB_N_VREGS,
  parameter int LANE_DEPTH = SB_LANE_DEPTH,
  localparam int IDX_W     = $clog2(LANE_DEPTH),
  localparam int BYTES     = DATA_W / 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [SB_VREG_W-1:0] wr_vreg,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [BYTES-1:0]     wr_be,
  input  logic [SB_VREG_W-1:0] rd_vreg,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [DATA_W-1:0]    rd_data
`ifdef VPU_SB_WRITTEN_TRACK_EN
  ,
  output logic [BYTES-1:0]     rd_written
`endif
);

  localparam int ENTRIES = N_VREGS * LANE_DEPTH;
  localparam int ADDR_W  = $clog2(ENTRIES);

  function automatic logic [ADDR_W-1:0] entry_addr(input logic [SB_VREG_W-1:0] v,
                                                   input logic [IDX_W-1:0]     i);
    return ADDR_W'(v) * ADDR_W'(LANE_DEPTH) + ADDR_W'(i);
  endfunction

  logic [DATA_W-1:0] mem [ENTRIES];
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  assign wr_addr = entry_addr(wr_vreg, wr_idx);
  assign rd_addr = entry_addr(rd_vreg, rd_idx);

  // NOTE: sequential state uses non-blocking assignments so every flop updates together at the edge.
  // NOTE: the store is reset explicitly because a check after reset must see an all-zero image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < ENTRIES; e++) mem[e] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < BYTES; k++) begin
        if (wr_be[k]) mem[wr_addr][k*8 +: 8] <= wr_data[k*8 +: 8];
      end
    end
  end

  // Reading the registered array means a same-cycle write is only seen next cycle.
  assign rd_data = mem[rd_addr];

`ifdef VPU_SB_WRITTEN_TRACK_EN
  logic [BYTES-1:0] written [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < ENTRIES; e++) written[e] <= '0;
    end else if (wr_en) begin
      written[wr_addr] <= written[wr_addr] | wr_be;
    end
  end

  assign rd_written = written[rd_addr];
`endif

endmodule

// File: rtl/vpu_vrf_shadow_checker.sv
// Cosim shadow of the VPU vector register file with a streaming compare engine.
// Optional VPU_SB_WRITTEN_TRACK_EN treats never-written bytes as mismatches and adds res_unwritten.
module vpu_vrf_shadow_checker
  import vpu_scoreboard_pkg::*;
#(
  parameter int N_LANES    = SB_N_LANES,
  parameter int DATA_W     = SB_DATA_W,
  parameter int N_VREGS    = SB_N_VREGS,
  parameter int LANE_DEPTH = SB_LANE_DEPTH,
  localparam int CNT_W     = SB_CNT_W,
  localparam int VREG_W    = SB_VREG_W,
  localparam int IDX_W     = $clog2(LANE_DEPTH),
  localparam int NBLK_W    = $clog2(N_LANES * LANE_DEPTH) + 1,
  localparam int BYTES     = DATA_W / 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_LANES-1:0]          wb_valid,
  input  logic [N_LANES*VREG_W-1:0]   wb_vreg,
  input  logic [N_LANES*IDX_W-1:0]    wb_idx,
  input  logic [N_LANES*DATA_W-1:0]   wb_data,
  input  logic [N_LANES*BYTES-1:0]    wb_be,
  input  logic                        chk_valid,
  output logic                        chk_ready,
  input  logic [VREG_W-1:0]           chk_vreg,
  input  logic [NBLK_W-1:0]           chk_nblk,
  input  logic [1:0]                  chk_sew,
  input  logic                        exp_valid,
  output logic                        exp_ready,
  input  logic [DATA_W-1:0]           exp_data,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic                        res_error,
  output logic [CNT_W-1:0]            res_elem_idx,
  output logic [CNT_W-1:0]            res_mm_cnt,
  output logic                        res_hazard
`ifdef VPU_SB_WRITTEN_TRACK_EN
  ,
  output logic                        res_unwritten
`endif
);

  // Block b lives in lane b%N_LANES at index b/N_LANES; N_LANES is a power of two.
  localparam int LANE_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  chk_state_e        state_q, state_d;
  logic [VREG_W-1:0] vreg_q;
  logic [NBLK_W-1:0] nblk_q;
  logic [NBLK_W-1:0] beat_q;
  sew_e              sew_q;
  chk_result_t       res_q;

  logic              chk_fire;
  logic              beat_fire;
  logic              last_beat;
  logic              hazard_hit;
  logic [LANE_W-1:0] lane_sel;
  logic [IDX_W-1:0]  idx_sel;
  logic [DATA_W-1:0] shadow_blk;
  logic [BYTES-1:0]  byte_diff;
  logic              blk_mismatch;
  logic [BYTE_W-1:0] first_byte;
  logic [CNT_W-1:0]  elem_calc;

  logic [DATA_W-1:0] lane_rd_data [N_LANES];

  assign lane_sel = beat_q[LANE_W-1:0];
  assign idx_sel  = beat_q[LANE_W +: IDX_W];

`ifdef VPU_SB_WRITTEN_TRACK_EN
  logic [BYTES-1:0] lane_rd_written [N_LANES];
  logic [BYTES-1:0] shadow_written;
  logic [BYTES-1:0] byte_unwritten;
  logic             unwritten_q;
`endif

  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    vpu_sb_lane_shadow #(
      .DATA_W     (DATA_W),
      .N_VREGS    (N_VREGS),
      .LANE_DEPTH (LANE_DEPTH)
    ) u_shadow (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wb_valid[l]),
      .wr_vreg    (wb_vreg[l*VREG_W +: VREG_W]),
      .wr_idx     (wb_idx[l*IDX_W +: IDX_W]),
      .wr_data    (wb_data[l*DATA_W +: DATA_W]),
      .wr_be      (wb_be[l*BYTES +: BYTES]),
      .rd_vreg    (vreg_q),
      .rd_idx     (idx_sel),
      .rd_data    (lane_rd_data[l])
`ifdef VPU_SB_WRITTEN_TRACK_EN
      ,
      .rd_written (lane_rd_written[l])
`endif
    );
  end

  assign shadow_blk = lane_rd_data[lane_sel];
`ifdef VPU_SB_WRITTEN_TRACK_EN
  assign shadow_written = lane_rd_written[lane_sel];
  assign byte_unwritten = ~shadow_written;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    byte_diff = '0;
    for (int k = 0; k < BYTES; k++) begin
      byte_diff[k] = (exp_data[k*8 +: 8] != shadow_blk[k*8 +: 8]);
    end
`ifdef VPU_SB_WRITTEN_TRACK_EN
    byte_diff = byte_diff | byte_unwritten;
`endif
  end

  assign blk_mismatch = |byte_diff;

  // Lowest differing byte wins: scan downward so the last hit is the lowest index.
  always_comb begin
    first_byte = '0;
    for (int k = BYTES - 1; k >= 0; k--) begin
      if (byte_diff[k]) first_byte = BYTE_W'(k);
    end
  end

  assign elem_calc = CNT_W'(beat_q) * (CNT_W'(BYTES) >> sew_q)
                   + CNT_W'(first_byte >> sew_q);

  always_comb begin
    hazard_hit = 1'b0;
    for (int l = 0; l < N_LANES; l++) begin
      if (wb_valid[l] && (wb_vreg[l*VREG_W +: VREG_W] == vreg_q)) hazard_hit = 1'b1;
    end
  end

  assign chk_fire  = chk_valid && chk_ready;
  assign beat_fire = exp_valid && exp_ready;
  assign last_beat = (beat_q == nblk_q - NBLK_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CHK_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CHK_IDLE: if (chk_valid)             state_d = (chk_nblk == '0) ? CHK_DONE : CHK_CMP;
      CHK_CMP:  if (exp_valid && last_beat) state_d = CHK_DONE;
      CHK_DONE: if (res_ready)             state_d = CHK_IDLE;
      default:                             state_d = CHK_IDLE;
    endcase
  end

  always_comb begin
    chk_ready = (state_q == CHK_IDLE);
    exp_ready = (state_q == CHK_CMP);
    res_valid = (state_q == CHK_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vreg_q <= '0;
      nblk_q <= '0;
      sew_q  <= SEW_8;
      beat_q <= '0;
      res_q  <= '0;
    end else if (chk_fire) begin
      vreg_q <= chk_vreg;
      nblk_q <= chk_nblk;
      sew_q  <= sew_e'(chk_sew);
      beat_q <= '0;
      res_q  <= '0;
    end else if (state_q == CHK_CMP) begin
      if (hazard_hit) res_q.hazard <= 1'b1;
      if (beat_fire) begin
        beat_q <= beat_q + NBLK_W'(1);
        if (blk_mismatch) begin
          res_q.mm_cnt <= sat_inc(res_q.mm_cnt);
          if (!res_q.error) begin
            res_q.error    <= 1'b1;
            res_q.elem_idx <= elem_calc;
          end
        end
      end
    end
  end

`ifdef VPU_SB_WRITTEN_TRACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      unwritten_q <= 1'b0;
    else if (chk_fire)               unwritten_q <= 1'b0;
    else if (beat_fire && |byte_unwritten) unwritten_q <= 1'b1;
  end

  assign res_unwritten = unwritten_q;
`endif

  assign res_error    = res_q.error;
  assign res_elem_idx = res_q.elem_idx;
  assign res_mm_cnt   = res_q.mm_cnt;
  assign res_hazard   = res_q.hazard;

endmodule

// File: tb/tb_vpu_vrf_shadow_checker.sv
// Randomized bench for vpu_vrf_shadow_checker against a byte-level vreg image model.
// Build with VPU_SB_WRITTEN_TRACK_EN to exercise the written-byte tracking variant.
module tb_vpu_vrf_shadow_checker;
  import vpu_scoreboard_pkg::*;

  localparam int NL   = 8;
  localparam int DW   = 64;
  localparam int NV   = 32;
  localparam int LD   = 32;
  localparam int IW   = 5;
  localparam int NBW  = 9;
  localparam int BY   = 8;
  localparam int VW   = 5;
  localparam int BLKS = NL * LD;
`ifdef VPU_SB_WRITTEN_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NL-1:0]     wb_valid;
  logic [NL*VW-1:0]  wb_vreg;
  logic [NL*IW-1:0]  wb_idx;
  logic [NL*DW-1:0]  wb_data;
  logic [NL*BY-1:0]  wb_be;
  logic              chk_valid;
  logic              chk_ready;
  logic [VW-1:0]     chk_vreg;
  logic [NBW-1:0]    chk_nblk;
  logic [1:0]        chk_sew;
  logic              exp_valid;
  logic              exp_ready;
  logic [DW-1:0]     exp_data;
  logic              res_valid;
  logic              res_ready;
  logic              res_error;
  logic [15:0]       res_elem_idx;
  logic [15:0]       res_mm_cnt;
  logic              res_hazard;
`ifdef VPU_SB_WRITTEN_TRACK_EN
  logic              res_unwritten;
`endif

  vpu_vrf_shadow_checker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_valid     (wb_valid),
    .wb_vreg      (wb_vreg),
    .wb_idx       (wb_idx),
    .wb_data      (wb_data),
    .wb_be        (wb_be),
    .chk_valid    (chk_valid),
    .chk_ready    (chk_ready),
    .chk_vreg     (chk_vreg),
    .chk_nblk     (chk_nblk),
    .chk_sew      (chk_sew),
    .exp_valid    (exp_valid),
    .exp_ready    (exp_ready),
    .exp_data     (exp_data),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_error    (res_error),
    .res_elem_idx (res_elem_idx),
    .res_mm_cnt   (res_mm_cnt),
    .res_hazard   (res_hazard)
`ifdef VPU_SB_WRITTEN_TRACK_EN
    ,
    .res_unwritten(res_unwritten)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  // Architectural view: vreg image as a flat byte array in block order.
  byte unsigned vrf_m [NV][BLKS*BY];
  bit           wr_m  [NV][BLKS*BY];
  logic [63:0]  exp_q [$];
  int           hz_lane = -1;
  int           hz_vreg = 0;

  task automatic model_clear();
    for (int v = 0; v < NV; v++)
      for (int j = 0; j < BLKS*BY; j++) begin
        vrf_m[v][j] = 8'h00;
        wr_m[v][j]  = 1'b0;
      end
  endtask

  task automatic model_write(input int l, input int v, input int i,
                             input logic [63:0] d, input logic [7:0] be);
    int blk;
    blk = i * NL + l;
    for (int k = 0; k < BY; k++) begin
      if (be[k]) begin
        vrf_m[v][blk*BY+k] = d[k*8 +: 8];
        wr_m[v][blk*BY+k]  = 1'b1;
      end
    end
  endtask

  function automatic logic [63:0] model_blk(input int v, input int b);
    logic [63:0] r;
    for (int k = 0; k < BY; k++) r[k*8 +: 8] = vrf_m[v][b*BY+k];
    return r;
  endfunction

  task automatic model_beat(input int v, input int b, input int sew, input logic [63:0] e,
                            output bit mm, output int elem, output bit unw);
    int first;
    first = -1;
    mm    = 1'b0;
    unw   = 1'b0;
    elem  = 0;
    for (int k = 0; k < BY; k++) begin
      bit u, d;
      u = TRACK && !wr_m[v][b*BY+k];
      d = (e[k*8 +: 8] != vrf_m[v][b*BY+k]) || u;
      if (u) unw = 1'b1;
      if (d) begin
        mm = 1'b1;
        if (first < 0) first = k;
      end
    end
    if (mm) elem = (b * (BY >> sew) + (first >> sew)) & 16'hFFFF;
  endtask

  task automatic clear_wb();
    wb_valid = '0;
    wb_be    = '0;
  endtask

  task automatic put_wb(input int l, input int v, input int i,
                        input logic [63:0] d, input logic [7:0] be);
    wb_valid[l]          = 1'b1;
    wb_vreg[l*VW +: VW]  = VW'(v);
    wb_idx[l*IW +: IW]   = IW'(i);
    wb_data[l*DW +: DW]  = d;
    wb_be[l*BY +: BY]    = be;
  endtask

  task automatic commit_wb();
    for (int l = 0; l < NL; l++) begin
      if (wb_valid[l])
        model_write(l, int'(wb_vreg[l*VW +: VW]), int'(wb_idx[l*IW +: IW]),
                    wb_data[l*DW +: DW], wb_be[l*BY +: BY]);
    end
  endtask

  task automatic tick();
    commit_wb();
    @(posedge clk);
    #1;
    clear_wb();
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    clear_wb();
    chk_valid = 1'b0;
    exp_valid = 1'b0;
    res_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_exp(input int v, input int nblk, input int flip_pct);
    exp_q.delete();
    for (int b = 0; b < nblk; b++) begin
      logic [63:0] blk;
      blk = model_blk(v, b);
      for (int k = 0; k < BY; k++)
        if ($urandom_range(0, 99) < flip_pct) blk[k*8 +: 8] ^= 8'($urandom_range(1, 255));
      exp_q.push_back(blk);
    end
  endtask

  task automatic random_writes(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      for (int l = 0; l < NL; l++) begin
        if ($urandom_range(0, 1) == 1)
          put_wb(l, $urandom_range(0, 7), $urandom_range(0, 5), {$urandom, $urandom},
                 ($urandom_range(0, 9) < 3) ? 8'hFF : 8'($urandom));
      end
      tick();
    end
  endtask

  task automatic do_check(input string tag, input int v, input int nblk, input int sew,
                          input int wr_pct, input int hold, input int want_err,
                          input int want_elem, input int want_mm, input int want_hz);
    bit e_err, e_hz, e_unw, mm, unw;
    int e_cnt, e_elem, elem, b, guard;
    e_err = 0; e_hz = 0; e_unw = 0; e_cnt = 0; e_elem = 0; b = 0; guard = 0;

    check({tag, "_chk_ready"}, 64'(chk_ready), 64'd1);
    chk_valid = 1'b1;
    chk_vreg  = VW'(v);
    chk_nblk  = NBW'(nblk);
    chk_sew   = 2'(sew);
    tick();
    chk_valid = 1'b0;

    while (b < nblk && guard < nblk * 8 + 20) begin
      bit ev;
      ev        = ($urandom_range(0, 3) != 0);
      exp_valid = ev;
      exp_data  = ev ? exp_q[b] : {$urandom, $urandom};
      check({tag, "_exp_ready"}, 64'(exp_ready), 64'd1);
      if ($urandom_range(0, 99) < wr_pct)
        put_wb($urandom_range(0, NL-1), ($urandom_range(0, 1) == 1) ? v : $urandom_range(0, 7),
               $urandom_range(0, 5), {$urandom, $urandom}, 8'($urandom));
      if (guard == 0 && hz_lane >= 0) put_wb(hz_lane, hz_vreg, 0, {$urandom, $urandom}, 8'hFF);
      for (int l = 0; l < NL; l++)
        if (wb_valid[l] && int'(wb_vreg[l*VW +: VW]) == v) e_hz = 1'b1;
      if (ev) begin
        model_beat(v, b, sew, exp_q[b], mm, elem, unw);
        if (unw) e_unw = 1'b1;
        if (mm) begin
          if (!e_err) e_elem = elem;
          e_err = 1'b1;
          if (e_cnt < 65535) e_cnt++;
        end
        b++;
      end
      guard++;
      tick();
    end
    exp_valid = 1'b0;
    if (b < nblk) check({tag, "_beat_timeout"}, 64'(b), 64'(nblk));

    check({tag, "_res_valid"}, 64'(res_valid), 64'd1);
    check({tag, "_exp_ready_done"}, 64'(exp_ready), 64'd0);
    check({tag, "_error"}, 64'(res_error), 64'(e_err));
    check({tag, "_elem_idx"}, 64'(res_elem_idx), 64'(e_elem));
    check({tag, "_mm_cnt"}, 64'(res_mm_cnt), 64'(e_cnt));
    check({tag, "_hazard"}, 64'(res_hazard), 64'(e_hz));
`ifdef VPU_SB_WRITTEN_TRACK_EN
    check({tag, "_unwritten"}, 64'(res_unwritten), 64'(e_unw));
`endif
    if (want_err >= 0)  check({tag, "_error_req"}, 64'(res_error), 64'(want_err));
    if (want_elem >= 0) check({tag, "_elem_req"}, 64'(res_elem_idx), 64'(want_elem));
    if (want_mm >= 0)   check({tag, "_mm_req"}, 64'(res_mm_cnt), 64'(want_mm));
    if (want_hz >= 0)   check({tag, "_hazard_req"}, 64'(res_hazard), 64'(want_hz));

    for (int h = 0; h < hold; h++) begin
      exp_valid = ($urandom_range(0, 1) == 1);
      exp_data  = {$urandom, $urandom};
      tick();
      check({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
      check({tag, "_hold_chk_ready"}, 64'(chk_ready), 64'd0);
      check({tag, "_hold_error"}, 64'(res_error), 64'(e_err));
      check({tag, "_hold_elem"}, 64'(res_elem_idx), 64'(e_elem));
      check({tag, "_hold_mm"}, 64'(res_mm_cnt), 64'(e_cnt));
    end
    exp_valid = 1'b0;

    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_res_valid_drop"}, 64'(res_valid), 64'd0);
    check({tag, "_chk_ready_back"}, 64'(chk_ready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_wb();
    wb_vreg   = '0;
    wb_idx    = '0;
    wb_data   = '0;
    chk_valid = 1'b0;
    chk_vreg  = '0;
    chk_nblk  = '0;
    chk_sew   = '0;
    exp_valid = 1'b0;
    exp_data  = '0;
    res_ready = 1'b0;
    apply_reset();

    check("rst_chk_ready", 64'(chk_ready), 64'd1);
    check("rst_exp_ready", 64'(exp_ready), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_error", 64'(res_error), 64'd0);
    check("rst_elem_idx", 64'(res_elem_idx), 64'd0);
    check("rst_mm_cnt", 64'(res_mm_cnt), 64'd0);
    check("rst_hazard", 64'(res_hazard), 64'd0);

    // Single matching block.
    put_wb(0, 3, 0, 64'h1122334455667788, 8'hFF);
    tick();
    exp_q.delete();
    exp_q.push_back(64'h1122334455667788);
    do_check("t1", 3, 1, 3, 0, 0, 0, 0, 0, 0);

    // 16 blocks across all lanes, block 9 byte 2 corrupted.
    for (int b = 0; b < 16; b++) begin
      put_wb(b % NL, 5, b / NL, {$urandom, $urandom}, 8'hFF);
      if (b % NL == NL - 1) tick();
    end
    fill_exp(5, 16, 0);
    exp_q[9] = exp_q[9] ^ 64'h0000_0000_00FF_0000;
    do_check("t2", 5, 16, 1, 0, 0, 1, 37, 1, 0);

    // exp beats in IDLE are ignored; empty check holds its result.
    exp_valid = 1'b1;
    exp_data  = {$urandom, $urandom};
    tick();
    check("t3_idle_exp_ready", 64'(exp_ready), 64'd0);
    exp_valid = 1'b0;
    exp_q.delete();
    do_check("t3", 4, 0, 0, 0, 5, 0, 0, 0, 0);

    // Hazard on the checked vreg only.
    fill_exp(7, 4, 0);
    hz_lane = 2;
    hz_vreg = 7;
    do_check("t4a", 7, 4, 3, 0, 0, -1, -1, -1, 1);
    hz_vreg = 8;
    fill_exp(7, 4, 0);
    do_check("t4b", 7, 4, 3, 0, 0, -1, -1, -1, 0);
    hz_lane = -1;

    // Reset in the middle of a compare.
    fill_exp(5, 8, 0);
    chk_valid = 1'b1;
    chk_vreg  = 5'd5;
    chk_nblk  = NBW'(8);
    chk_sew   = 2'd3;
    tick();
    chk_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      exp_valid = 1'b1;
      exp_data  = exp_q[b];
      tick();
    end
    exp_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("t5_rst_res_valid", 64'(res_valid), 64'd0);
    check("t5_rst_chk_ready", 64'(chk_ready), 64'd1);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("t5_post_chk_ready", 64'(chk_ready), 64'd1);
    check("t5_post_res_valid", 64'(res_valid), 64'd0);
    check("t5_post_exp_ready", 64'(exp_ready), 64'd0);
    exp_q.delete();
    for (int b = 0; b < 8; b++) exp_q.push_back(64'd0);
    do_check("t5", 5, 8, 3, 0, 0, TRACK ? -1 : 0, -1, TRACK ? -1 : 0, 0);

`ifdef VPU_SB_WRITTEN_TRACK_EN
    // Upper half never written; exp zeros there still miscompare.
    apply_reset();
    put_wb(0, 9, 0, 64'h11223344_aabbccdd, 8'h0F);
    tick();
    exp_q.delete();
    exp_q.push_back(64'h00000000_aabbccdd);
    do_check("t6", 9, 1, 0, 0, 0, 1, 4, 1, 0);
`endif

    // Randomized traffic, including one full-length compare.
    for (int r = 0; r < 25; r++) begin
      int v, nblk;
      random_writes($urandom_range(1, 6));
      v    = $urandom_range(0, 7);
      nblk = (r == 12) ? BLKS : $urandom_range(0, 48);
      fill_exp(v, nblk, 4);
      do_check($sformatf("rnd%0d", r), v, nblk, $urandom_range(0, 3), 20,
               $urandom_range(0, 3), -1, -1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
